// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 16x-oversampled UART receiver feeding an RX FIFO, with a level interrupt while data is pending.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds sticky parity_err in STATUS[9].
module uart_rx #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0100,
  parameter logic [15:0] BAUD_DIV   = 16'd54,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        rx_valid,
  input  logic        rx,
  output logic        rx_interrupt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic          rx_meta_q, rx_s_q, irq_q;
  logic [15:0]   div_q, div_d, tick_cnt_q, tick_cnt_d;
  logic [2:0]    state_q, state_d, b_cnt_q, b_cnt_d;
  logic [3:0]    s_cnt_q, s_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d, pbad_q, pbad_d;
  logic          hit, wr_hit, div_wr, stat_wr, tick, push, do_push, pop, full, not_empty;
  logic          set_ferr, set_perr, set_ovr;
  logic [31:0]   status, count_ext;
  logic          unused_bits;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign rx_valid  = read_enable & hit;
  assign wr_hit    = write_enable & hit;
  assign div_wr    = wr_hit & (addr[3:2] == 2'd2);
  assign stat_wr   = wr_hit & (addr[3:2] == 2'd1);
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = rx_valid & (addr[3:2] == 2'd0) & not_empty;
  assign count_ext = 32'(count_q);
  assign status    = {22'b0, perr_q, count_ext[4:0], ferr_q, ovr_q, full, not_empty};
  assign tick      = (tick_cnt_q == div_q - 16'd1);
  assign rx_interrupt = irq_q;
  assign unused_bits  = ^{addr[1:0], write_data[31:16], count_ext[31:5]};

  always_comb begin
    read_data = 32'b0;
    if (rx_valid) begin
      case (addr[3:2])
        2'd0:    read_data = not_empty ? {24'b0, mem_q[rd_ptr_q]} : 32'b0;
        2'd1:    read_data = status;
        2'd2:    read_data = {16'b0, div_q};
        default: read_data = 32'b0;
      endcase
    end
  end

  // A DIV write restarts the oversample phase so the new rate takes effect cleanly.
  always_comb begin
    div_d      = div_q;
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    if (div_wr) begin
      div_d      = (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
      tick_cnt_d = 16'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_cnt_d  = s_cnt_q;
    b_cnt_d  = b_cnt_q;
    shift_d  = shift_q;
    pbad_d   = pbad_q;
    push     = 1'b0;
    set_ferr = 1'b0;
    set_perr = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: if (!rx_s_q) begin
          s_cnt_d = 4'd0;
          state_d = S_START;
        end
        S_START: if (s_cnt_q == 4'd7) begin
          if (rx_s_q) state_d = S_IDLE;
          else begin
            s_cnt_d = 4'd0;
            b_cnt_d = 3'd0;
            pbad_d  = 1'b0;
            state_d = S_DATA;
          end
        end else s_cnt_d = s_cnt_q + 4'd1;
        S_DATA: if (s_cnt_q == 4'd15) begin
          s_cnt_d          = 4'd0;
          shift_d[b_cnt_q] = rx_s_q;
          b_cnt_d          = b_cnt_q + 3'd1;
          if (b_cnt_q == 3'd7) state_d = S_AFTER_DATA;
        end else s_cnt_d = s_cnt_q + 4'd1;
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (s_cnt_q == 4'd15) begin
          s_cnt_d = 4'd0;
          state_d = S_STOP;
          if ((^shift_q) != rx_s_q) begin
            pbad_d   = 1'b1;
            set_perr = 1'b1;
          end
        end else s_cnt_d = s_cnt_q + 4'd1;
`endif
        S_STOP: if (s_cnt_q == 4'd15) begin
          if (rx_s_q) begin
            push    = ~pbad_q;
            state_d = S_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_d  = S_BREAK;
          end
        end else s_cnt_d = s_cnt_q + 4'd1;
        S_BREAK: if (rx_s_q) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A pop frees the slot in the same edge, so a simultaneous push into a full FIFO is kept.
  always_comb begin
    do_push  = push & (~full | pop);
    set_ovr  = push & full & ~pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop) count_d = count_q + 1'b1;
    if (pop && !do_push) count_d = count_q - 1'b1;
    ovr_d  = (ovr_q  & ~(stat_wr & write_data[2])) | set_ovr;
    ferr_d = (ferr_q & ~(stat_wr & write_data[3])) | set_ferr;
    perr_d = (perr_q & ~(stat_wr & write_data[9])) | set_perr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      div_q      <= BAUD_DIV;
      tick_cnt_q <= 16'd0;
      state_q    <= S_IDLE;
      s_cnt_q    <= 4'd0;
      b_cnt_q    <= 3'd0;
      shift_q    <= 8'd0;
      pbad_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      b_cnt_q    <= b_cnt_d;
      shift_q    <= shift_d;
      pbad_q     <= pbad_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      irq_q      <= not_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: register vector table, directed frame sequences and randomized bytes against a queue model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam logic [31:0] BASE  = 32'h2000_0100;
  localparam int          DEPTH = 16;
  localparam int          BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'b0;
  logic [31:0] write_data = 32'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] read_data;
  logic        rx_valid;
  logic        rx = 1'b1;
  logic        rx_interrupt;

  always #5 clk = ~clk;

  uart_rx #(.BASE_ADDR(BASE), .BAUD_DIV(16'd54), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable),
    .read_data(read_data), .rx_valid(rx_valid), .rx(rx), .rx_interrupt(rx_interrupt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: received bytes in arrival order plus the sticky flags.
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endfunction

  function automatic logic [31:0] exp_status();
    int n;
    n = mq.size();
    return {22'b0, m_perr, n[4:0], m_ferr, m_ovr, n == DEPTH, n != 0};
  endfunction

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    addr = a;
    read_enable = 1'b1;
    #1;
    d = read_data;
    v = rx_valid;
    @(posedge clk);
    #1 read_enable = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    write_data = d;
    write_enable = 1'b1;
    @(posedge clk);
    #1 write_enable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic v;
    bus_rd(a, d, v);
    check(name, d, exp);
  endtask

  task automatic drive_bits(input logic [7:0] b, input logic par_ok);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    repeat (BIT_CLKS) @(negedge clk);
`else
    if (!par_ok) rx = 1'b1;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_bits(b, 1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    model_push(b);
  endtask

  // Polls STATUS once per cycle until not_empty shows; k_hit is the poll index, -1 on timeout.
  task automatic poll_ne(output int k_hit, output logic [31:0] st, output logic irq_at);
    k_hit = -1;
    st = 32'b0;
    irq_at = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      addr = BASE + 32'h4;
      read_enable = 1'b1;
      #1;
      if (read_data[0]) begin
        k_hit = k;
        st = read_data;
        irq_at = rx_interrupt;
      end
      @(posedge clk);
      #1 read_enable = 1'b0;
      if (k_hit >= 0) break;
    end
  endtask

  vec_t vecs[14];

  initial begin
    int k_cal, k_hit, n;
    logic [31:0] d, st;
    logic v, irq_at;
    logic [7:0] b, exp_b;

    vecs[0]  = '{1'b0, BASE + 32'h4,  32'h0,         32'h0000_0000, 1'b1};
    vecs[1]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0036, 1'b1};
    vecs[2]  = '{1'b0, BASE,          32'h0,         32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,         32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, BASE + 32'h18, 32'h0,         32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h3000_0104, 32'h0,         32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, BASE + 32'h8,  32'h0,         32'h0,         1'b0};
    vecs[7]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0001, 1'b1};
    vecs[8]  = '{1'b1, BASE + 32'h8,  32'hFFFF_0004, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, BASE + 32'h18, 32'h0000_0009, 32'h0,         1'b0};
    vecs[10] = '{1'b0, BASE + 32'h8,  32'h0,         32'h0000_0004, 1'b1};
    vecs[11] = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[12] = '{1'b1, BASE + 32'h4,  32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[13] = '{1'b0, BASE + 32'h4,  32'h0,         32'h0000_0000, 1'b1};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_irq", 32'(rx_interrupt), 32'd0);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_rdata", read_data, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].we) bus_wr(vecs[i].a, vecs[i].wd);
      else begin
        bus_rd(vecs[i].a, d, v);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
        check($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].exp_v));
      end
    end

    // Frame 0xA5; its push timing relative to the DIV write is reused for the pop/push collision.
    bus_wr(BASE + 32'h8, 32'd4);
    drive_bits(8'hA5, 1'b1);
    rx = 1'b1;
    poll_ne(k_cal, st, irq_at);
    check("a5_seen", 32'(k_cal >= 0), 32'd1);
    check("a5_status", st, 32'h11);
    check("a5_irq_same_cycle", 32'(irq_at), 32'd0);
    @(negedge clk);
    check("a5_irq_next_cycle", 32'(rx_interrupt), 32'd1);
    repeat (BIT_CLKS) @(negedge clk);
    model_push(8'hA5);
    rd_chk("a5_data", BASE, mq.pop_front());
    rd_chk("a5_status_after", BASE + 32'h4, exp_status());
    check("a5_irq_cleared", 32'(rx_interrupt), 32'd0);
    rd_chk("empty_data_read", BASE, 32'h0);

    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    rd_chk("glitch_status", BASE + 32'h4, exp_status());

    for (int i = 0; i <= 16; i++) send_byte(8'(i));
    rd_chk("ovr_status", BASE + 32'h4, 32'h107);
    rd_chk("ovr_status_model", BASE + 32'h4, exp_status());
    bus_wr(BASE + 32'h4, 32'h4);
    m_ovr = 1'b0;
    rd_chk("ovr_cleared", BASE + 32'h4, 32'h103);

    // Pop timed to the push edge while full: both happen, no overrun.
    if (k_cal > 0) begin
      bus_wr(BASE + 32'h8, 32'd4);
      drive_bits(8'hEE, 1'b1);
      rx = 1'b1;
      d = 32'hDEAD_BEEF;
      for (int k = 0; k < k_cal; k++) begin
        @(negedge clk);
        addr = (k == k_cal - 1) ? BASE : BASE + 32'h4;
        read_enable = 1'b1;
        #1;
        if (k == k_cal - 1) d = read_data;
        @(posedge clk);
        #1 read_enable = 1'b0;
      end
      repeat (BIT_CLKS) @(negedge clk);
      check("collide_pop_data", d, 32'(mq.pop_front()));
      model_push(8'hEE);
      rd_chk("collide_status", BASE + 32'h4, 32'h103);
    end
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      exp_b = mq.pop_front();
      rd_chk($sformatf("drain%0d", i), BASE, 32'(exp_b));
    end
    rd_chk("drain_status", BASE + 32'h4, exp_status());

    drive_bits(8'h3C, 1'b1);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    m_ferr = 1'b1;
    rd_chk("ferr_status", BASE + 32'h4, 32'h8);
    send_byte(8'h55);
    rd_chk("after_ferr_status", BASE + 32'h4, exp_status());
    rd_chk("after_ferr_data", BASE, 32'(mq.pop_front()));
    bus_wr(BASE + 32'h4, 32'h8);
    m_ferr = 1'b0;
    rd_chk("ferr_cleared", BASE + 32'h4, exp_status());

`ifdef UART_RX_PARITY_EN
    drive_bits(8'h07, 1'b0);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    m_perr = 1'b1;
    rd_chk("perr_status", BASE + 32'h4, 32'h200);
    bus_wr(BASE + 32'h4, 32'h200);
    m_perr = 1'b0;
    rd_chk("perr_cleared", BASE + 32'h4, exp_status());
`else
    bus_wr(BASE + 32'h4, 32'h200);
    rd_chk("bit9_ignored", BASE + 32'h4, exp_status());
`endif

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        repeat ($urandom_range(0, 5)) @(negedge clk);
        send_byte(b);
      end
      rd_chk($sformatf("rand%0d_status", r), BASE + 32'h4, exp_status());
      while (mq.size() != 0) begin
        exp_b = mq.pop_front();
        rd_chk($sformatf("rand%0d_data", r), BASE, 32'(exp_b));
      end
    end

    send_byte(8'h81);
    rx = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    @(negedge clk);
    check("midreset_irq", 32'(rx_interrupt), 32'd0);
    rd_chk("midreset_status", BASE + 32'h4, exp_status());
    rd_chk("midreset_div", BASE + 32'h8, 32'h36);
    rd_chk("midreset_data", BASE, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped 8N1 UART receiver. It is the receive-side counterpart of the existing uart transmitter.
- Samples the asynchronous `rx` pin with 16x oversampling and pushes received bytes into an RX FIFO.
- The CPU reads the FIFO through the same load/store decode path as the timer and the uart block.
- Asserts a level interrupt while data is pending.

Parameters:
- BASE_ADDR, 32'h2000_0100, word-aligned base of the 3-register window (decode: addr[31:4] == BASE_ADDR[31:4]).
- BAUD_DIV, 16'd54, reset value of DIV: clocks per oversample tick (100 MHz / 115200 / 16).
- FIFO_DEPTH, 16, RX FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  CPU data address.
- write_data  in  32  CPU store data.
- write_enable  in  1  store strobe, pre-qualified by address decode in top.
- read_enable  in  1  load strobe, pre-qualified by address decode in top.
- read_data  out  32  register read data (combinational).
- rx_valid  out  1  high when read_enable is high and addr hits the window.
- rx  in  1  serial input, asynchronous, idle high.
- rx_interrupt  out  1  level interrupt: FIFO non-empty.

Behaviour:
- Reset values:
  - read_data=0, rx_valid=0, rx_interrupt=0.
  - FIFO empty; sticky flags cleared; DIV=BAUD_DIV.
  - Synchronizer flops=1; FSM=IDLE.
- Registers (offset addr[3:2]):
  - 0x0 RX_DATA (RO): read_data={24'b0, head}. A read with FIFO non-empty pops on that clock edge. A read with FIFO empty returns 0 and does not pop.
  - 0x4 STATUS:
    - Bits: [0] not_empty, [1] full, [2] overrun (sticky), [3] frame_err (sticky), [8:4] count (0..FIFO_DEPTH), other bits 0.
    - Write-1-to-clear on bits 2 and 3; other written bits ignored.
  - 0x8 DIV (RW): [15:0] divisor. Writing 0 stores 1. Upper bits read 0.
  - 0xC: reads 0, writes ignored.
- Reads have no side effect other than the RX_DATA pop. read_data is 0 when rx_valid=0.
- Input path: rx passes through a 2-flop synchronizer (rx_s); the FSM uses only rx_s.
- Tick generator:
  - tick_cnt counts 0..DIV-1; tick pulses for one clock when tick_cnt==DIV-1, then wraps to 0.
  - A DIV write resets tick_cnt to 0. An in-flight frame may be corrupted; this is not flagged beyond the normal frame checks.
- FSM (sample counter s_cnt counts ticks, bit counter b_cnt 0..7):
  - IDLE: when rx_s==0 at a tick, clear s_cnt and go to START.
  - START: on the 8th tick (mid start bit), if rx_s==1 treat it as a glitch and return to IDLE. Otherwise clear s_cnt and go to DATA.
  - DATA: every 16th tick, sample rx_s into shift[b_cnt], LSB first. After b_cnt==7, go to STOP.
  - STOP: on the 16th tick, sample rx_s.
    - If 1, push the byte and go to IDLE.
    - If 0, set frame_err, discard the byte and go to BREAK.
  - BREAK: remain until rx_s==1 at a tick, then go to IDLE.
- FIFO rules:
  - Push and pop in the same cycle: both occur and count is unchanged. This holds even when full, so no overrun is raised.
  - Push while full with no pop: byte dropped, overrun set, FIFO contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses count, which is 5 bits wide for the default depth and sized $clog2(FIFO_DEPTH)+1.
- Sticky flag precedence: a W1C in the same cycle as a set event leaves the flag set.
- rx_interrupt is registered as not_empty, one cycle after the push or pop that changes it.
- Reset asserted mid-frame: the FSM returns to IDLE and the partial byte is lost. The FIFO, flags and DIV return to their reset values.
- Latency: a byte is visible in STATUS.not_empty on the clock after the STOP-sample tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit is sampled one bit period after data bit 7, before STOP.
  - A mismatch sets sticky parity_err (STATUS bit 9, W1C) and drops the byte. The stop check still runs.
- Undefined: 8N1 frame; STATUS bit 9 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read STATUS → 0x0000_0000; read DIV → 0x0036; rx_interrupt=0.
- DIV=4 (bit = 64 clocks); drive frame 0xA5 on rx → STATUS=0x11 and rx_interrupt=1 one cycle later. Read RX_DATA → 0xA5; STATUS then reads 0x00.
- DIV=4; 30-clock low glitch on rx, then high → FSM returns to IDLE, FIFO count 0, no flags.
- DIV=4; send 17 bytes 0x00..0x10 without reading → STATUS shows full=1, count=16, overrun=1. The 16 reads return 0x00..0x0F. Writing 0x4 to STATUS clears overrun.
- DIV=4; frame 0x3C with stop bit low, held low for 3 bit times → frame_err=1, count 0. The next valid frame 0x55 is received correctly.
- Pop while full and a push landing in the same cycle → count stays 16, overrun stays 0; with UART_RX_PARITY_EN, frame 0x07 with parity 0 → parity_err=1, byte dropped.
